// File: rtl/stopwatch_pkg.sv
// Shared state encoding and default timing values for the stopwatch controller.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_LAP   = 2'b11
   } sw_state_e;

   localparam int DEBOUNCE_CYCLES_DEF = 32'd1_000_000;
   localparam int TICK_DIV_DEF        = 32'd10_000_000;

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: 2-flop synchronizer, stable-level debouncer and a
// single-cycle press pulse on each accepted rising level.
module btn_debounce
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
)(
   input  logic clock,
   input  logic reset,
   input  logic btn,
   output logic press
);

   localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_r;
   logic          sync2_r;
   logic          level_r;
   logic          press_r;
   logic [CW-1:0] cnt_r;

   // Synchronizer for the raw asynchronous button input.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= btn;
         sync2_r <= sync1_r;
      end
   end

   // Any cycle where the synchronized level matches the accepted one restarts the run.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_r   <= '0;
         level_r <= 1'b0;
         press_r <= 1'b0;
      end else if (sync2_r == level_r) begin
         cnt_r   <= '0;
         press_r <= 1'b0;
      end else if (cnt_r == CNT_MAX) begin
         cnt_r   <= '0;
         level_r <= sync2_r;
         press_r <= sync2_r;
      end else begin
         cnt_r   <= cnt_r + CW'(1'b1);
         press_r <= 1'b0;
      end
   end

   assign press = press_r;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced buttons drive a 4-state FSM that gates a
// 0.1 s prescaler and issues tick/clear pulses to the digit counters.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int TICK_DIV        = TICK_DIV_DEF
)(
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_ss,
   input  logic       btn_lap,
   input  logic       btn_clr,
   output logic       run,
   output logic       tick,
   output logic       clear,
   output logic       hold,
   output logic [1:0] state
);

   localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

   logic          press_ss_s, press_lap_s, press_clr_s;
   logic          ev_ss_s, ev_lap_s, ev_clr_s;
   sw_state_e     state_r, state_next_s;
   logic          run_r, hold_r, clear_r, tick_r;
   logic          run_next_s, hold_next_s, clear_next_s;
   logic [PW-1:0] presc_r;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
      .clock(clock), .reset(reset), .btn(btn_ss),  .press(press_ss_s));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
      .clock(clock), .reset(reset), .btn(btn_lap), .press(press_lap_s));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
      .clock(clock), .reset(reset), .btn(btn_clr), .press(press_clr_s));

   // Same-cycle presses resolve clr > ss > lap; the losers are dropped.
   assign ev_clr_s = press_clr_s;
   assign ev_ss_s  = press_ss_s & ~press_clr_s;
   assign ev_lap_s = press_lap_s & ~press_clr_s & ~press_ss_s;

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (ev_ss_s) state_next_s = ST_RUN;
            else         state_next_s = ST_IDLE;
         end
         ST_RUN: begin
            if (ev_ss_s)       state_next_s = ST_PAUSE;
            else if (ev_lap_s) state_next_s = ST_LAP;
            else               state_next_s = ST_RUN;
         end
         ST_LAP: begin
            if (ev_lap_s)     state_next_s = ST_RUN;
            else if (ev_ss_s) state_next_s = ST_PAUSE;
            else              state_next_s = ST_LAP;
         end
         ST_PAUSE: begin
            if (ev_ss_s)       state_next_s = ST_RUN;
            else if (ev_clr_s) state_next_s = ST_IDLE;
            else               state_next_s = ST_PAUSE;
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Output values decoded from the next state so they register alongside it.
   always_comb begin
      run_next_s   = (state_next_s == ST_RUN) || (state_next_s == ST_LAP);
      hold_next_s  = (state_next_s == ST_LAP);
      clear_next_s = ev_clr_s && ((state_r == ST_IDLE) || (state_r == ST_PAUSE));
   end

   // State and registered FSM outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ST_IDLE;
         run_r   <= 1'b0;
         hold_r  <= 1'b0;
         clear_r <= 1'b0;
      end else begin
         state_r <= state_next_s;
         run_r   <= run_next_s;
         hold_r  <= hold_next_s;
         clear_r <= clear_next_s;
      end
   end

   // Prescaler holds its phase while stopped so resume keeps the sub-tick position.
   always_ff @(posedge clock) begin
      if (reset) begin
         presc_r <= '0;
         tick_r  <= 1'b0;
      end else if (clear_next_s) begin
         presc_r <= '0;
         tick_r  <= 1'b0;
      end else if (run_r) begin
         if (presc_r == PRE_MAX) begin
            presc_r <= '0;
            tick_r  <= 1'b1;
         end else begin
            presc_r <= presc_r + PW'(1'b1);
            tick_r  <= 1'b0;
         end
      end else begin
         presc_r <= presc_r;
         tick_r  <= 1'b0;
      end
   end

   assign run   = run_r;
   assign tick  = tick_r;
   assign clear = clear_r;
   assign hold  = hold_r;
   assign state = state_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random button activity,
// every cycle compared against a behavioural model built from windows and tables.
module tb_stopwatch_ctrl;

   localparam int DB = 4;
   localparam int TD = 5;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       btn_ss = 1'b0, btn_lap = 1'b0, btn_clr = 1'b0;
   logic       run, tick, clear, hold;
   logic [1:0] state;

   int n_checks = 0;
   int n_pass   = 0;

   // model: raw/synced sample windows per button, transition table, running phase
   bit raw_h [3][$];
   bit syn_h [3][$];
   bit lvl  [3];
   bit pend [3];
   int NEXT [4][4] = '{'{0, 1, 0, 0}, '{1, 2, 3, 1}, '{2, 1, 2, 0}, '{3, 2, 1, 3}};
   int m_state = 0, m_phase = 0;
   bit m_run = 0, m_hold = 0, m_clear = 0, m_tick = 0;

   int cyc = 0;
   int tick_q [$];
   int clear_cnt = 0;
   int run_rise = -1;
   bit prev_run = 0;

   always #5 clock = ~clock;

   stopwatch_ctrl #(.DEBOUNCE_CYCLES(DB), .TICK_DIV(TD)) dut (
      .clock(clock), .reset(reset), .btn_ss(btn_ss), .btn_lap(btn_lap), .btn_clr(btn_clr),
      .run(run), .tick(tick), .clear(clear), .hold(hold), .state(state));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
   endtask

   task automatic model_edge();
      bit raw [3];
      bit ev [3];
      int evk, old_state;
      bit old_run, synced, all_diff;
      raw[0] = btn_ss; raw[1] = btn_lap; raw[2] = btn_clr;
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            raw_h[i].delete(); syn_h[i].delete(); lvl[i] = 0; pend[i] = 0;
         end
         m_state = 0; m_phase = 0; m_run = 0; m_hold = 0; m_clear = 0; m_tick = 0;
         return;
      end
      for (int i = 0; i < 3; i++) ev[i] = pend[i];
      evk = ev[2] ? 3 : (ev[0] ? 1 : (ev[1] ? 2 : 0));
      old_state = m_state;
      old_run   = m_run;
      m_tick  = old_run && (m_phase == TD - 1);
      m_clear = (evk == 3) && (old_state == 0 || old_state == 2);
      if (m_clear)      m_phase = 0;
      else if (old_run) m_phase = (m_phase + 1) % TD;
      m_state = NEXT[old_state][evk];
      m_run   = (m_state == 1) || (m_state == 3);
      m_hold  = (m_state == 3);
      // a level is accepted once the last DB synchronized samples all disagree with it
      for (int i = 0; i < 3; i++) begin
         pend[i] = 0;
         synced = (raw_h[i].size() >= 2) ? raw_h[i][raw_h[i].size() - 2] : 1'b0;
         raw_h[i].push_back(raw[i]);
         if (raw_h[i].size() > 2) void'(raw_h[i].pop_front());
         syn_h[i].push_back(synced);
         if (syn_h[i].size() > DB) void'(syn_h[i].pop_front());
         all_diff = (syn_h[i].size() == DB);
         foreach (syn_h[i][j]) if (syn_h[i][j] == lvl[i]) all_diff = 0;
         if (all_diff) begin
            lvl[i]  = ~lvl[i];
            pend[i] = lvl[i];
         end
      end
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
      cyc++;
      chk("state", state, m_state);
      chk("run",   run,   m_run);
      chk("hold",  hold,  m_hold);
      chk("clear", clear, m_clear);
      chk("tick",  tick,  m_tick);
      chk("tick_clear_excl", tick & clear, 0);
      if (tick === 1'b1)  tick_q.push_back(cyc);
      if (clear === 1'b1) clear_cnt++;
      if (run === 1'b1 && !prev_run) run_rise = cyc;
      prev_run = (run === 1'b1);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic press(input int which, input int hold_cyc, input int gap);
      if (which == 0) btn_ss = 1'b1; else if (which == 1) btn_lap = 1'b1; else btn_clr = 1'b1;
      steps(hold_cyc);
      if (which == 0) btn_ss = 1'b0; else if (which == 1) btn_lap = 1'b0; else btn_clr = 1'b0;
      steps(gap);
   endtask

   task automatic wait_phase(input int p);
      for (int i = 0; i < 2 * TD; i++) begin
         if (m_phase == p) break;
         step();
      end
   endtask

   initial begin
      int n;
      reset = 1'b1;
      steps(2);
      reset = 1'b0;
      step();
      chk("reset_state", state, 0);

      // short bounce never reaches the debounce threshold
      btn_ss = 1'b1; step(); btn_ss = 1'b0; step(); btn_ss = 1'b1; step(); btn_ss = 1'b0;
      steps(10);
      chk("bounce_idle", state, 0);

      // ss held 10 cycles: RUN within 8 cycles, then steady 5-cycle ticks
      btn_ss = 1'b1;
      steps(8);
      chk("ss_latency_state", state, 1);
      chk("ss_latency_run", run, 1);
      steps(2);
      btn_ss = 1'b0;
      tick_q.delete();
      steps(15);
      chk("tick_count", tick_q.size(), 3);
      if (tick_q.size() >= 3) begin
         chk("tick_gap1", tick_q[1] - tick_q[0], TD);
         chk("tick_gap2", tick_q[2] - tick_q[1], TD);
      end

      // pause with the prescaler parked at 3, resume: first tick 2 cycles after run
      wait_phase(1);
      press(0, 8, 0);
      chk("pause_state", state, 2);
      tick_q.delete();
      steps(20);
      chk("pause_ticks", tick_q.size(), 0);
      tick_q.delete();
      press(0, 8, 4);
      chk("resume_state", state, 1);
      chk("resume_tick", (tick_q.size() > 0) ? tick_q[0] - run_rise : -1, 2);

      // lap freezes display while ticks continue, second lap releases it
      press(1, 8, 2);
      chk("lap_hold", hold, 1);
      chk("lap_state", state, 3);
      tick_q.delete();
      steps(10);
      chk("lap_ticks", tick_q.size(), 2);
      press(1, 8, 2);
      chk("unlap_hold", hold, 0);
      chk("unlap_state", state, 1);

      // clr and ss together in PAUSE: clr wins, one clear, prescaler back to 0
      press(0, 8, 6);
      clear_cnt = 0;
      btn_ss = 1'b1; btn_clr = 1'b1;
      steps(8);
      btn_ss = 1'b0; btn_clr = 1'b0;
      steps(8);
      chk("clr_pulses", clear_cnt, 1);
      chk("clr_state", state, 0);
      tick_q.delete();
      press(0, 8, 8);
      chk("post_clear_tick", (tick_q.size() > 0) ? tick_q[0] - run_rise : -1, TD);

      // reset mid-LAP with ss held: everything zero, ss re-fires after a full debounce
      press(1, 8, 2);
      wait_phase(2);
      btn_ss = 1'b1;
      reset  = 1'b1;
      step();
      reset  = 1'b0;
      chk("rst_state", state, 0);
      chk("rst_run", run, 0);
      chk("rst_hold", hold, 0);
      chk("rst_tick", tick, 0);
      chk("rst_clear", clear, 0);
      n = 0;
      while (state !== 2'b01 && n < 20) begin
         step();
         n++;
      end
      chk("held_retrigger", n, 7);
      btn_ss = 1'b0;
      steps(10);

      // random button activity with occasional reset
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 9) == 0) btn_ss  = ~btn_ss;
         if ($urandom_range(0, 9) == 0) btn_lap = ~btn_lap;
         if ($urandom_range(0, 11) == 0) btn_clr = ~btn_clr;
         reset = ($urandom_range(0, 399) == 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000: consecutive stable cycles needed to accept a button level (10 ms at 100 MHz).
REQ-002 Parameter TICK_DIV, default 10_000_000: clock cycles per 0.1 s tick (100 MHz).
REQ-003 clock  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 btn_ss  input  1  raw start/stop pushbutton, asynchronous, active-high.
REQ-006 btn_lap  input  1  raw lap/split pushbutton, asynchronous, active-high.
REQ-007 btn_clr  input  1  raw clear pushbutton, asynchronous, active-high.
REQ-008 run  output  1  high while the digit counters are timing.
REQ-009 tick  output  1  single-cycle 0.1 s count-enable pulse to the digit counters.
REQ-010 clear  output  1  single-cycle synchronous clear pulse to the digit counters.
REQ-011 hold  output  1  high while the display shows a frozen lap value.
REQ-012 state  output  2  current FSM state, encoded IDLE=00, RUN=01, PAUSE=10, LAP=11.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer, then a debouncer.
REQ-014 The debounced level SHALL change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-015 A press event SHALL be a 1-cycle pulse on each 0->1 edge of the debounced level; release SHALL generate no event.
REQ-016 Same-cycle press events SHALL be prioritised clr > ss > lap; lower-priority events in that cycle SHALL be discarded.
REQ-017 IDLE: ss -> RUN; clr -> stay IDLE and pulse clear; lap ignored.
REQ-018 RUN: ss -> PAUSE; lap -> LAP; clr ignored.
REQ-019 LAP: lap -> RUN (hold drops); ss -> PAUSE (hold drops); clr ignored.
REQ-020 PAUSE: ss -> RUN; clr -> IDLE and pulse clear; lap ignored.
REQ-021 Outputs SHALL be registered: run=1 in RUN and LAP; hold=1 in LAP only; clear asserts in the cycle after the clr event; state reflects the registered FSM state.
REQ-022 The prescaler is ceil(log2(TICK_DIV)) bits wide. While run=1 it SHALL increment each cycle; at TICK_DIV-1 it SHALL wrap to 0 and tick SHALL pulse for that one cycle.
REQ-023 While run=0 the prescaler SHALL hold its value, so pause/resume keeps sub-tick phase; tick SHALL be 0.
REQ-024 When clear pulses, the prescaler SHALL return to 0 in the same cycle.
REQ-025 tick and clear SHALL never be high in the same cycle.

Reset
REQ-026 When reset=1 at a clock edge, the following SHALL take effect: state=IDLE; run, tick, clear and hold=0; prescaler=0; synchronizers, debounce counters and debounced levels=0.
REQ-027 Reset SHALL override every event in the same cycle, including in mid-debounce or mid-tick.
REQ-028 A button held through reset SHALL produce one press event after DEBOUNCE_CYCLES plus the synchronizer latency.

Structure
REQ-029 A shared package stopwatch_pkg SHALL hold the state enum/localparams and the default DEBOUNCE_CYCLES and TICK_DIV values.
REQ-030 Sub-module btn_debounce (synchronizer, debouncer, edge pulse; parameter DEBOUNCE_CYCLES) SHALL be instantiated three times.
REQ-031 The FSM and prescaler SHALL live in stopwatch_ctrl.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=5)
REQ-032 Hold btn_ss high 10 cycles from IDLE -> one press; state=01 and run=1 within 2+4+2 cycles; tick pulses every 5 cycles.
REQ-033 Toggle btn_ss every cycle for 3 cycles, then hold 0 -> no press event; state stays 00.
REQ-034 Press ss in RUN with the prescaler at 3, wait 20 cycles, press ss again -> state 10, then 01; no tick while paused; first tick 2 cycles after run reasserts.
REQ-035 In RUN press lap, then lap again -> hold=1 with state=11 and ticks continuing, then hold=0 with state=01.
REQ-036 In PAUSE press clr and ss in the same cycle -> state=00; exactly one clear pulse; prescaler=0; no transition to RUN.
REQ-037 Assert reset for 1 cycle in LAP with the prescaler at 2 -> next cycle state=00, all outputs 0; a held button re-triggers only after a full debounce.
